// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one Start/Done/Ack multiplier among N_REQ requesters.
// Define MULT_ARB_ZERO_BYPASS_EN to answer zero-operand requests directly with product 0.
module mult_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 4
) (
   input  logic                   ARB_Clock,
   input  logic                   ARB_Reset,
   input  logic [N_REQ-1:0]       ARB_Req,
   input  logic [N_REQ*WIDTH-1:0] ARB_Multiplicand,
   input  logic [N_REQ*WIDTH-1:0] ARB_Multiplier,
   output logic [N_REQ-1:0]       ARB_Resp_Valid,
   output logic [2*WIDTH-1:0]     ARB_Product,
   output logic                   ARB_Busy,
   output logic                   ARB_Mul_Start,
   output logic [WIDTH-1:0]       ARB_Mul_A,
   output logic [WIDTH-1:0]       ARB_Mul_B,
   input  logic                   ARB_Mul_Done,
   input  logic [2*WIDTH-1:0]     ARB_Mul_Product,
   output logic                   ARB_Mul_Ack
);
   localparam int IW = $clog2(N_REQ);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d, win_q, win_d, pick, idx;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, pick_a, pick_b;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [N_REQ-1:0] resp_q, resp_d;
   logic start_q, start_d, ack_q, ack_d, busy_q, busy_d;
`ifdef MULT_ARB_ZERO_BYPASS_EN
   logic zero;
   assign zero = (pick_a == '0) || (pick_b == '0);
`endif
   // Search downward so the nearest requester after ptr overwrites the others.
   always_comb begin
      pick = ptr_q;
      idx = '0;
      pick_a = '0;
      pick_b = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = IW'((int'(ptr_q) + k) % N_REQ);
         if (ARB_Req[idx]) pick = idx;
      end
      for (int i = 0; i < N_REQ; i++)
         if (pick == IW'(i)) begin
            pick_a = ARB_Multiplicand[i*WIDTH +: WIDTH];
            pick_b = ARB_Multiplier[i*WIDTH +: WIDTH];
         end
   end
   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      win_d = win_q;
      a_d = a_q;
      b_d = b_q;
      prod_d = prod_q;
      case (state_q)
         IDLE:
            if (|ARB_Req) begin
               win_d = pick;
               ptr_d = pick;
               a_d = pick_a;
               b_d = pick_b;
`ifdef MULT_ARB_ZERO_BYPASS_EN
               state_d = zero ? RESP : ISSUE;
               prod_d = zero ? '0 : prod_q;
`else
               state_d = ISSUE;
`endif
            end
         ISSUE: state_d = WAIT;
         WAIT:
            if (ARB_Mul_Done) begin
               state_d = RESP;
               prod_d = ARB_Mul_Product;
            end
         default: state_d = IDLE;
      endcase
      // Outputs are precomputed from the next state so they leave the flops aligned with it.
      start_d = state_d == ISSUE;
      busy_d = state_d != IDLE;
      ack_d = (state_q == WAIT) && ARB_Mul_Done;
      for (int i = 0; i < N_REQ; i++) resp_d[i] = (state_d == RESP) && (win_d == IW'(i));
   end
   always_ff @(posedge ARB_Clock) begin
      if (ARB_Reset) begin
         state_q <= IDLE;
         ptr_q <= IW'(N_REQ - 1);
         win_q <= '0;
         a_q <= '0;
         b_q <= '0;
         prod_q <= '0;
         resp_q <= '0;
         start_q <= 1'b0;
         ack_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         win_q <= win_d;
         a_q <= a_d;
         b_q <= b_d;
         prod_q <= prod_d;
         resp_q <= resp_d;
         start_q <= start_d;
         ack_q <= ack_d;
         busy_q <= busy_d;
      end
   end
   assign ARB_Resp_Valid = resp_q;
   assign ARB_Product = prod_q;
   assign ARB_Busy = busy_q;
   assign ARB_Mul_Start = start_q;
   assign ARB_Mul_A = a_q;
   assign ARB_Mul_B = b_q;
   assign ARB_Mul_Ack = ack_q;
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one shift-add multiplier (the Start/Done/Ack controlled datapath) among N_REQ requesters. It selects one pending request, registers that requester's operands, drives the multiplier's Start/Ack handshake, and returns the product to the winner with a one-cycle response pulse. It sits between the client blocks and the multiplier top level, and is the only block that drives the multiplier's Start and Ack inputs.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 4, operand width; product is 2*WIDTH
- ARB_Clock  in  1  system clock, rising edge
- ARB_Reset  in  1  synchronous, active-high reset
- ARB_Req  in  N_REQ  per-requester level request
- ARB_Multiplicand  in  N_REQ*WIDTH  packed operands; requester i at bits [i*WIDTH +: WIDTH]
- ARB_Multiplier  in  N_REQ*WIDTH  packed operands, same packing
- ARB_Resp_Valid  out  N_REQ  one-hot, one-cycle pulse to the served requester
- ARB_Product  out  2*WIDTH  result; valid when any ARB_Resp_Valid bit is high
- ARB_Busy  out  1  high in every state except IDLE
- ARB_Mul_Start  out  1  to multiplier Start
- ARB_Mul_A  out  WIDTH  to multiplier operand A (multiplicand)
- ARB_Mul_B  out  WIDTH  to multiplier operand B (multiplier)
- ARB_Mul_Done  in  1  from multiplier Done (level, held until Ack)
- ARB_Mul_Product  in  2*WIDTH  from multiplier product register
- ARB_Mul_Ack  out  1  to multiplier Ack

## Operation
- The FSM states are IDLE, ISSUE, WAIT and RESP. All outputs decode from registered state and registers (Moore). No combinational path exists from input to output.
- IDLE:
  - If ARB_Req is non-zero, pick the winner by round-robin. The search starts at ptr+1 and wraps modulo N_REQ.
  - Latch the winner index, its multiplicand into ARB_Mul_A, and its multiplier into ARB_Mul_B.
  - Set ptr to the winner index.
  - Go to ISSUE.
- ISSUE: ARB_Mul_Start=1 for exactly one cycle, then go to WAIT.
- WAIT: stay until ARB_Mul_Done=1. On that cycle, register ARB_Mul_Product into the product register and go to RESP.
- RESP, one cycle:
  - ARB_Mul_Ack=1.
  - ARB_Resp_Valid[winner]=1.
  - ARB_Product shows the captured value.
  - Then go to IDLE.
- ARB_Mul_A and ARB_Mul_B stay stable from the cycle after the grant until RESP ends. The multiplier loads its operands in its Init cycle, which follows Start.
- ARB_Product holds its last value until the next RESP.
- ARB_Mul_Done is ignored in IDLE and ISSUE.
- If Done never arrives, the FSM stays in WAIT indefinitely. There is no timeout.
- Requests sampled while Busy wait. There is no queueing beyond the level ARB_Req.
- A requester must drop ARB_Req in the cycle after its Resp_Valid pulse, otherwise it is re-arbitrated as a new request. Round-robin gives it lowest priority on the next grant.
- Reset values:
  - state=IDLE, ptr=N_REQ-1, so requester 0 wins first.
  - All outputs are 0, including ARB_Mul_A, ARB_Mul_B and ARB_Product.
- Reset mid-operation:
  - The arbiter returns to IDLE and the transaction is dropped with no Resp_Valid.
  - ARB_Reset must also drive the multiplier controller's reset, so both sides restart together.

## Timing
- Grant: ARB_Req is sampled in IDLE at cycle 0, ISSUE (Start=1) is cycle 1, WAIT begins at cycle 2.
- If ARB_Mul_Done is first sampled high at cycle k, RESP (Ack plus Resp_Valid) is cycle k+1 and IDLE is cycle k+2.
- The multiplier leaves Done at the edge ending cycle k+1, so Done=0 is guaranteed by cycle k+2.
- Back-to-back throughput: the next Start comes at the earliest at k+3.
- Overhead per transaction is 3 cycles plus the multiplier latency.

## Configuration
- MULT_ARB_ZERO_BYPASS_EN defined:
  - In IDLE, if the winner's multiplicand or multiplier is 0, go directly to RESP without Start and without Ack.
  - ARB_Product=0 and ptr still advances.
  - Response latency is 1 cycle (request at cycle 0, Resp_Valid at cycle 1).
- MULT_ARB_ZERO_BYPASS_EN undefined: zero operands take the normal multiplier path.

## Test plan
- Single request: Req=0001, A0=4'd13, B0=4'd11 -> Start pulse 1 cycle after the grant, Resp_Valid=0001 with Product=8'd143 one cycle after Done, Ack high in that same cycle only.
- Round-robin: Req=1111 held, operands i*3 and i+1 -> grants in order 0,1,2,3,0, products 0,6,18,36,0, exactly one Resp_Valid bit per response.
- Contention fairness: Req0 held permanently and Req2 raised mid-transaction -> requester 2 is served next, before requester 0 repeats.
- Handshake corner: Done held high for 5 cycles by a behavioural multiplier model -> single RESP, Ack exactly 1 cycle, no second response; Done in IDLE ignored.
- Reset mid-WAIT: assert ARB_Reset during WAIT -> next cycle IDLE with all outputs 0, no Resp_Valid; the next request is served by requester 0 first.
- Zero bypass: A1=0, B1=4'd9 -> with MULT_ARB_ZERO_BYPASS_EN, Resp_Valid=0010 and Product=0 at cycle 1 with no Start; without the macro, normal path with Product=0.
